// File: rtl/wr_512b_to_bram_pkg.sv
// Shared constants and helpers for the connected-domain filter row datapath.
// Used by both the 512-bit row reader and the row writer.
package wr_512b_to_bram_pkg;

    localparam int DATA_W        = 32;
    localparam int WORDS_PER_ROW = 16;
    localparam int ROW_W         = 9;
    localparam int K_W           = $clog2(WORDS_PER_ROW);
    localparam int ADDR_W        = ROW_W + K_W;
    localparam int ROW_BITS      = DATA_W * WORDS_PER_ROW;

    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_REQ = 2'd1,
        ST_WR_REL = 2'd2,
        ST_DONE   = 2'd3
    } wr_state_e;

    // Concatenation, not addition: a row's words can never spill into the next row.
    function automatic logic [ADDR_W-1:0] row_word_addr(
        input logic [ROW_W-1:0] row,
        input logic [K_W-1:0]   k
    );
        return {row, k};
    endfunction

endpackage

// File: rtl/wr_512b_to_bram.sv
// Row writer: stores one latched 512-bit row into the TOP BRAM as 16
// ascending 32-bit word writes over a four-phase trig/done handshake.
module wr_512b_to_bram
    import wr_512b_to_bram_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_trig,
    output logic                o_done,
    output logic                o_busy,
    input  logic [ROW_W-1:0]    i_wr_row_num,
    input  logic [ROW_BITS-1:0] i_wr_data_512b,
    output logic [ADDR_W-1:0]   o_wr_to_bram_addr,
    output logic [DATA_W-1:0]   o_wr_to_bram_data,
    output logic                o_wr_to_bram_trig,
    input  logic                i_wr_to_bram_done
);

    wr_state_e             state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ROW_BITS-1:0]   data_q, data_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  trig_q, trig_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            data_q  <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            data_q  <= data_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        data_d  = data_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        trig_d  = trig_q;
        done_d  = done_q;

        unique case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                trig_d = 1'b0;
                if (i_trig) begin
                    row_d   = i_wr_row_num;
                    data_d  = i_wr_data_512b;
                    k_d     = '0;
                    addr_d  = row_word_addr(i_wr_row_num, '0);
                    wdata_d = i_wr_data_512b[DATA_W-1:0];
                    trig_d  = 1'b1;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (i_wr_to_bram_done) begin
                    trig_d  = 1'b0;
                    state_d = ST_WR_REL;
                end
            end
            ST_WR_REL: begin
                // Next word is only requested once the controller has released done.
                if (!i_wr_to_bram_done) begin
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        addr_d  = row_word_addr(row_q, k_d);
                        wdata_d = data_q[int'(k_d)*DATA_W +: DATA_W];
                        trig_d  = 1'b1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                if (!i_trig) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign o_done            = done_q;
    assign o_busy            = busy_q;
    assign o_wr_to_bram_addr = addr_q;
    assign o_wr_to_bram_data = wdata_q;
    assign o_wr_to_bram_trig = trig_q;

endmodule

// File: doc/wr_512b_to_bram.md
Name: wr_512b_to_bram

Overview:
- Write-side counterpart of the 512-bit row reader.
- Takes one 512-bit row image and a 9-bit row number, then stores the row into the TOP BRAM as 16 sequential 32-bit word writes.
- Uses the TOP BRAM write-controller trig/done bus.
- Sits beside the row reader in the connected-domain filter, so filtered rows can be written back to the frame BRAM.

Parameters:
- DATA_W, 32, BRAM word width in bits.
- WORDS_PER_ROW, 16, words per row (DATA_W*WORDS_PER_ROW = 512).
- ROW_W, 9, row number width (512 rows).
- ADDR_W, 13, BRAM word address width = ROW_W + log2(WORDS_PER_ROW).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_trig  in  1  level trigger; a new write is started only from IDLE.
- o_done  out  1  row write complete; held per the DONE rules below.
- o_busy  out  1  high in every state except IDLE.
- i_wr_row_num  in  9  destination row, 0-511.
- i_wr_data_512b  in  512  row image to store.
- o_wr_to_bram_addr  out  13  word address to the BRAM write controller.
- o_wr_to_bram_data  out  32  word data to the BRAM write controller.
- o_wr_to_bram_trig  out  1  per-word write request.
- i_wr_to_bram_done  in  1  per-word write acknowledge from the controller.

Behaviour:
- Reset values:
  - All outputs are 0: o_done, o_busy, o_wr_to_bram_addr, o_wr_to_bram_data, o_wr_to_bram_trig.
  - Internal row/data latches are 0; state is IDLE; word index is 0.
- Every output is registered.
- Word mapping:
  - Word k (0..15) carries i_wr_data_512b[32k+31:32k].
  - Word k is written to address {row, k[3:0]}, i.e. row*16+k.
  - Words are issued in ascending k.
  - This matches the reader's assembly order.
- States: IDLE, WR_REQ, WR_REL, DONE.
- IDLE:
  - o_done=0 and o_wr_to_bram_trig=0.
  - On i_trig=1, at the same edge: latch i_wr_row_num and i_wr_data_512b, set k=0, go to WR_REQ.
  - The inputs are sampled only at this edge; later changes to them are ignored.
- WR_REQ:
  - Drive addr/data for word k and hold o_wr_to_bram_trig=1.
  - Stay in WR_REQ until i_wr_to_bram_done=1.
  - On that edge: trig<=0, go to WR_REL.
- WR_REL (four-phase handshake):
  - Wait for i_wr_to_bram_done=0.
  - If k=15, go to DONE; otherwise k<=k+1 and go to WR_REQ.
  - addr/data stay stable until the next WR_REQ.
- DONE:
  - o_done<=1.
  - If i_trig=0, go to IDLE; o_done clears on the next cycle, so it is high for at least one cycle.
  - If i_trig stays 1, remain in DONE with o_done=1.
  - There is no retrigger without i_trig first going low.
- Per-word timing:
  - Minimum 3 cycles per word when the controller answers done in the cycle after trig and drops it one cycle later.
  - A full row therefore takes at least 48 cycles plus IDLE/DONE overhead.
- i_trig deasserted mid-row: no abort. The row completes and DONE then lasts exactly one cycle.
- i_wr_to_bram_done high while in IDLE/DONE: ignored.
- i_wr_to_bram_done already high on entry to WR_REQ: treated as an acknowledge for the current word. The controller must not do this; verification flags it as a protocol error.
- Async reset mid-operation:
  - Immediate return to IDLE with all outputs 0; the partially written row is not rolled back.
  - The next trigger restarts from k=0.
- Address arithmetic never wraps across rows: k is 4 bits and the row is concatenated, not added.

Decomposition:
- Shared package (filter-wide, also used by the reader):
  - ROW_W, DATA_W, WORDS_PER_ROW, ADDR_W constants.
  - Row-word address helper (row, k) -> addr.
  - State encodings as localparams.
- No sub-module is needed. The 512->32 word selection is an indexed part-select on the latched row inside this block.

Test Plan:
- Row 10, data word k = 0xA5000000+k, controller acks after 1 cycle -> 16 writes at addr 0x0A0..0x0AF with data 0xA5000000..0xA500000F in order; o_done rises after the 16th done falls.
- Row 511, all-ones data -> addresses 0x1FF0..0x1FFF, no write to 0x0000; every data word 0xFFFFFFFF.
- Controller delays done by 5 cycles per word -> trig held high 5+ cycles per word with addr/data stable; next trig only after done has been seen low.
- i_trig held high through completion, then dropped 4 cycles later -> o_done high for those cycles, cleared one cycle after i_trig=0; no second row write.
- i_trig dropped after word 3; i_wr_data_512b and i_wr_row_num changed mid-row -> all 16 words still use the latched values; o_done high exactly 1 cycle.
- i_rstn pulsed low while word 7 is in WR_REQ -> all outputs 0 immediately; the next trigger writes words 0..15 from the beginning.
